// File: rtl/uncached_wbuf_axi.sv
// rtl/uncached_wbuf_axi.sv - uncached access engine with posted write buffer and single-beat AXI master
package uncached_wbuf_axi_pkg;

  typedef struct packed {
    logic        awvalid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bready;
    logic        arvalid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        rready;
  } axi_req_t;

  typedef struct packed {
    logic        awready;
    logic        wready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } axi_resp_t;

endpackage

module uncached_wbuf_axi
  import uncached_wbuf_axi_pkg::*;
#(
  parameter int WBUF_DEPTH   = 4,
  parameter bit STRICT_ORDER = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uncached_read,
  input  logic        uncached_write,
  input  logic [31:0] address,
  input  logic [31:0] wrdata,
  input  logic [3:0]  byteenable,
  output logic        uncached_stall,
  output logic [31:0] uncached_rddata,
  output axi_req_t    axi_req,
  input  axi_resp_t   axi_resp,
  output logic        wbuf_empty
);

  localparam int PW = $clog2(WBUF_DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;
  typedef enum logic [2:0] {R_IDLE, R_WAIT, R_AR, R_R, R_DONE} r_state_t;

  logic [31:0]   fifo_addr [WBUF_DEPTH];
  logic [31:0]   fifo_data [WBUF_DEPTH];
  logic [3:0]    fifo_be   [WBUF_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          full, push, pop;

  w_state_t      w_state, w_next;
  r_state_t      r_state, r_next;
  logic          aw_pend, w_pend;
  logic [31:0]   r_addr;
  logic          addr_hit, read_blocked;
  logic          unused_resp;

  // Response codes are not acted on; only the handshakes matter.
  assign unused_resp = ^{axi_resp.bresp, axi_resp.rresp};

  assign full  = (count == (PW+1)'(WBUF_DEPTH));
  assign push  = uncached_write && !full;
  assign pop   = (w_state == W_RESP) && axi_resp.bvalid;

  assign wbuf_empty = (count == '0) && (w_state == W_IDLE);

  // Entry storage: the head stays in place until its B arrives, so it also serves as the in-flight copy.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= address;
      fifo_data[wr_ptr] <= wrdata;
      fifo_be[wr_ptr]   <= byteenable;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Write engine state register.
  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  // Write engine next state: address and data channels finish independently before waiting on B.
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: if (count != '0) w_next = W_SEND;
      W_SEND: if ((!aw_pend || axi_resp.awready) && (!w_pend || axi_resp.wready)) w_next = W_RESP;
      W_RESP: if (axi_resp.bvalid) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Per-channel outstanding flags for AW and W, armed when an entry is launched.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
    end else if ((w_state == W_IDLE) && (count != '0)) begin
      aw_pend <= 1'b1;
      w_pend  <= 1'b1;
    end else begin
      if (axi_req.awvalid && axi_resp.awready) aw_pend <= 1'b0;
      if (axi_req.wvalid && axi_resp.wready)   w_pend  <= 1'b0;
    end
  end

  // Word-address hazard against every occupied slot; the in-flight entry is still the head slot.
  always_comb begin
    addr_hit = 1'b0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if (({1'b0, PW'(i) - rd_ptr} < count) && (fifo_addr[i][31:2] == r_addr[31:2]))
        addr_hit = 1'b1;
    end
  end

  assign read_blocked = STRICT_ORDER ? !wbuf_empty : addr_hit;

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  // Read FSM next state.
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE: if (uncached_read) r_next = R_WAIT;
      R_WAIT: if (!read_blocked) r_next = R_AR;
      R_AR:   if (axi_resp.arready) r_next = R_R;
      R_R:    if (axi_resp.rvalid) r_next = R_DONE;
      R_DONE: r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Read address latch and returned data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr          <= '0;
      uncached_rddata <= '0;
    end else begin
      if ((r_state == R_IDLE) && uncached_read) r_addr <= address;
      if ((r_state == R_R) && axi_resp.rvalid)  uncached_rddata <= axi_resp.rdata;
    end
  end

  assign uncached_stall = (uncached_write && full)
                        || ((r_state == R_IDLE) && uncached_read)
                        || (r_state == R_WAIT) || (r_state == R_AR) || (r_state == R_R);

  // AXI request drive: AW/W from the FIFO head, AR from the latched read address.
  always_comb begin
    axi_req         = '0;
    axi_req.awvalid = (w_state == W_SEND) && aw_pend;
    axi_req.awaddr  = fifo_addr[rd_ptr];
    axi_req.awsize  = 3'b010;
    axi_req.awburst = 2'b01;
    axi_req.wvalid  = (w_state == W_SEND) && w_pend;
    axi_req.wdata   = fifo_data[rd_ptr];
    axi_req.wstrb   = fifo_be[rd_ptr];
    axi_req.wlast   = 1'b1;
    axi_req.bready  = (w_state == W_RESP);
    axi_req.arvalid = (r_state == R_AR);
    axi_req.araddr  = r_addr;
    axi_req.arsize  = 3'b010;
    axi_req.arburst = 2'b01;
    axi_req.rready  = (r_state == R_R);
  end

endmodule

// File: tb/tb_uncached_wbuf_axi.sv
// tb/tb_uncached_wbuf_axi.sv - directed bench for uncached_wbuf_axi (instance 0 strict, instance 1 relaxed)
module tb_uncached_wbuf_axi;
  import uncached_wbuf_axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  rd, wr;
  logic [31:0] addr [2];
  logic [31:0] wdat [2];
  logic [3:0]  be   [2];
  logic [1:0]  stall, empty;
  logic [31:0] rdata [2];
  axi_req_t    req   [2];

  logic [1:0]  aw_en, w_en, b_en, ar_en, r_en;
  logic [31:0] r_val [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axi_resp_t   resp;
    logic        aw_hs, w_hs;
    logic        aw_got, w_got, b_pend, r_pend;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt;
    logic [31:0] aw_log [16];
    logic [31:0] w_log  [16];
    logic [3:0]  s_log  [16];

    uncached_wbuf_axi #(.WBUF_DEPTH(4), .STRICT_ORDER(g == 0)) dut (
      .clk             (clk),
      .rst             (rst),
      .uncached_read   (rd[g]),
      .uncached_write  (wr[g]),
      .address         (addr[g]),
      .wrdata          (wdat[g]),
      .byteenable      (be[g]),
      .uncached_stall  (stall[g]),
      .uncached_rddata (rdata[g]),
      .axi_req         (req[g]),
      .axi_resp        (resp),
      .wbuf_empty      (empty[g])
    );

    assign aw_hs = req[g].awvalid && resp.awready;
    assign w_hs  = req[g].wvalid && resp.wready;

    // Slave responses gated by the per-instance enables.
    always_comb begin
      resp         = '0;
      resp.awready = aw_en[g];
      resp.wready  = w_en[g];
      resp.bvalid  = b_pend && b_en[g];
      resp.arready = ar_en[g];
      resp.rvalid  = r_pend && r_en[g];
      resp.rdata   = r_val[g];
    end

    // Slave bookkeeping: logs AW/W beats, raises B after both, raises R after AR.
    always @(posedge clk) begin
      if (rst) begin
        aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
        aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0;
      end else begin
        if (aw_hs) begin
          aw_log[aw_cnt[3:0]] <= req[g].awaddr;
          aw_cnt <= aw_cnt + 1;
        end
        if (w_hs) begin
          w_log[w_cnt[3:0]] <= req[g].wdata;
          s_log[w_cnt[3:0]] <= req[g].wstrb;
          w_cnt <= w_cnt + 1;
        end
        if (resp.bvalid && req[g].bready) begin
          b_pend <= 1'b0;
          b_cnt  <= b_cnt + 1;
        end
        if ((aw_got || aw_hs) && (w_got || w_hs)) begin
          b_pend <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
        end else begin
          aw_got <= aw_got || aw_hs; w_got <= w_got || w_hs;
        end
        if (req[g].arvalid && resp.arready) begin
          r_pend <= 1'b1;
          ar_cnt <= ar_cnt + 1;
        end
        if (resp.rvalid && req[g].rready) r_pend <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rd = '0; wr = '0;
    aw_en = '1; w_en = '1; b_en = '1; ar_en = '1; r_en = '1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int first_ar_b;
    bit done, seen;
    rd = '0; wr = '0;
    for (int g = 0; g < 2; g++) begin
      addr[g] = '0; wdat[g] = '0; be[g] = '0; r_val[g] = '0;
    end
    aw_en = '1; w_en = '1; b_en = '1; ar_en = '1; r_en = '1;

    // Reset values
    rst = 1'b1;
    tick(); tick(); settle();
    check("rst_valids", {req[0].awvalid, req[0].wvalid, req[0].arvalid, req[0].bready, req[0].rready}, 0);
    check("rst_rddata", rdata[0], 0);
    check("rst_empty", empty[0], 1);
    check("rst_stall", stall[0], 0);
    rst = 1'b0;

    // Single write, zero-wait slave
    do_reset();
    tick(); wr[0] = 1; addr[0] = 32'h1FD0_F000; wdat[0] = 32'hDEAD_BEEF; be[0] = 4'b0011; settle();
    check("t1_stall", stall[0], 0);
    tick(); wr[0] = 0; settle();
    check("t1_not_empty", empty[0], 0);
    tick(); settle();
    check("t1_awvalid", req[0].awvalid, 1);
    check("t1_wvalid", req[0].wvalid, 1);
    check("t1_awaddr", req[0].awaddr, 32'h1FD0_F000);
    check("t1_wdata", req[0].wdata, 32'hDEAD_BEEF);
    check("t1_wstrb", req[0].wstrb, 4'b0011);
    check("t1_wlast", req[0].wlast, 1);
    check("t1_awsize", req[0].awsize, 3'b010);
    tick(); settle();
    check("t1_bready", req[0].bready, 1);
    tick(); settle();
    check("t1_empty", empty[0], 1);
    check("t1_aw_count", g_dut[0].aw_cnt, 1);

    // Full buffer: 5 writes with AW and B held off
    do_reset();
    aw_en[0] = 0; b_en[0] = 0;
    for (int i = 0; i < 4; i++) begin
      tick(); wr[0] = 1; addr[0] = 32'h1000 + 32'(i * 4); wdat[0] = 32'hA0 + 32'(i); be[0] = 4'hF; settle();
      check($sformatf("t2_accept%0d", i), stall[0], 0);
    end
    tick(); addr[0] = 32'h1010; wdat[0] = 32'hA4; settle();
    check("t2_full", stall[0], 1);
    tick(); settle();
    check("t2_full_hold", stall[0], 1);
    tick(); aw_en[0] = 1; b_en[0] = 1; settle();
    check("t2_release", stall[0], 1);
    tick(); settle();
    check("t2_pop_cycle_stall", stall[0], 1);
    check("t2_pop_cycle_bready", req[0].bready, 1);
    tick(); settle();
    check("t2_accept_after_pop", stall[0], 0);
    tick(); wr[0] = 0; settle();
    for (int k = 0; k < 60 && !empty[0]; k++) begin tick(); settle(); end
    check("t2_drain", empty[0], 1);
    check("t2_aw_count", g_dut[0].aw_cnt, 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_order_addr%0d", i), g_dut[0].aw_log[i], 32'h1000 + 32'(i * 4));
      check($sformatf("t2_order_data%0d", i), g_dut[0].w_log[i], 32'hA0 + 32'(i));
    end

    // Minimum read latency, empty buffer, strict instance
    do_reset();
    r_val[0] = 32'h1234_5678;
    tick(); rd[0] = 1; addr[0] = 32'h2000; settle();
    check("t3a_req_stall", stall[0], 1);
    for (int k = 1; k < 4; k++) begin
      tick(); settle();
      check($sformatf("t3a_stall_c%0d", k), stall[0], 1);
    end
    tick(); settle();
    check("t3a_done", stall[0], 0);
    check("t3a_rddata", rdata[0], 32'h1234_5678);
    tick(); settle();
    check("t3a_one_cycle", stall[0], 1);

    // Strict ordering: read waits for three buffered writes
    do_reset();
    r_val[0] = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      tick(); wr[0] = 1; addr[0] = 32'h3000 + 32'(i * 4); wdat[0] = 32'(i); be[0] = 4'hF; settle();
    end
    tick(); wr[0] = 0; rd[0] = 1; addr[0] = 32'h5000; settle();
    first_ar_b = -1; done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (req[0].arvalid && first_ar_b < 0) first_ar_b = g_dut[0].b_cnt;
      if (!stall[0]) done = 1;
      else begin tick(); settle(); end
    end
    check("t3_ar_after_third_b", first_ar_b, 3);
    check("t3_done", done, 1);
    check("t3_rddata", rdata[0], 32'h1234_5678);
    tick(); settle();
    check("t3_one_cycle", stall[0], 1);

    // Relaxed ordering: non-matching read bypasses, matching read waits
    do_reset();
    aw_en[1] = 0; b_en[1] = 0; r_val[1] = 32'hCAFE_F00D;
    tick(); wr[1] = 1; addr[1] = 32'h100; wdat[1] = 32'h11; be[1] = 4'hF; settle();
    tick(); wr[1] = 0; rd[1] = 1; addr[1] = 32'h200; settle();
    tick(); settle();
    tick(); settle();
    check("t4_ar_issued", req[1].arvalid, 1);
    check("t4_ar_addr", req[1].araddr, 32'h200);
    check("t4_write_pending", empty[1], 0);
    tick(); settle();
    tick(); settle();
    check("t4_read_done", stall[1], 0);
    check("t4_rddata", rdata[1], 32'hCAFE_F00D);
    tick(); rd[1] = 0; settle();
    check("t4_idle_stall", stall[1], 0);
    tick(); rd[1] = 1; addr[1] = 32'h100; settle();
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick(); settle();
      if (req[1].arvalid) seen = 1;
    end
    check("t4_hazard_hold", seen, 0);
    tick(); aw_en[1] = 1; b_en[1] = 1; settle();
    first_ar_b = -1; done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (req[1].arvalid && first_ar_b < 0) first_ar_b = g_dut[1].b_cnt;
      if (!stall[1]) done = 1;
      else begin tick(); settle(); end
    end
    check("t4_ar_after_b", first_ar_b, 1);
    check("t4_hazard_done", done, 1);
    tick(); rd[1] = 0; settle();

    // AW and W handshakes in different cycles
    do_reset();
    aw_en[0] = 0; b_en[0] = 0;
    tick(); wr[0] = 1; addr[0] = 32'h4000; wdat[0] = 32'h55; be[0] = 4'b1000; settle();
    tick(); wr[0] = 0; settle();
    tick(); settle();
    check("t5_send_aw", req[0].awvalid, 1);
    check("t5_send_w", req[0].wvalid, 1);
    tick(); settle();
    check("t5_w_dropped", req[0].wvalid, 0);
    check("t5_aw_held", req[0].awvalid, 1);
    tick(); aw_en[0] = 1; settle();
    check("t5_aw_held2", req[0].awvalid, 1);
    tick(); settle();
    check("t5_resp_bready", req[0].bready, 1);
    check("t5_resp_busy", empty[0], 0);
    tick(); settle();
    check("t5_no_pop_without_b", empty[0], 0);
    b_en[0] = 1;
    tick(); settle();
    check("t5_popped", empty[0], 1);
    check("t5_single_aw", g_dut[0].aw_cnt, 1);
    check("t5_single_w", g_dut[0].w_cnt, 1);
    check("t5_wstrb", g_dut[0].s_log[0], 4'b1000);

    // Reset in R_R and W_SEND
    do_reset();
    aw_en[1] = 0; r_en[1] = 0;
    tick(); wr[1] = 1; addr[1] = 32'h300; wdat[1] = 32'h77; be[1] = 4'hF; settle();
    tick(); wr[1] = 0; rd[1] = 1; addr[1] = 32'h400; settle();
    for (int k = 0; k < 4; k++) begin tick(); settle(); end
    check("t6_in_rr", req[1].rready, 1);
    check("t6_in_wsend", req[1].awvalid, 1);
    tick(); rst = 1; rd[1] = 0; settle();
    tick(); rst = 0; settle();
    check("t6_valids", {req[1].awvalid, req[1].wvalid, req[1].arvalid, req[1].bready, req[1].rready}, 0);
    check("t6_empty", empty[1], 1);
    check("t6_stall", stall[1], 0);
    aw_en[1] = 1;
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      tick(); settle();
      if (req[1].awvalid || !empty[1]) seen = 1;
    end
    check("t6_fifo_cleared", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uncached_wbuf_axi.md
Name: uncached_wbuf_axi

Overview:
Uncached memory-access engine between the CPU data bus uncached channel (uncached_read/uncached_write/uncached_stall/uncached_rddata) and a single-beat AXI master port (axi_req_t/axi_resp_t).
Uncached writes are posted into a parametrised FIFO write buffer and retired one at a time over AW/W/B.
Uncached reads are single-beat AR/R transactions, ordered against buffered writes according to a mode parameter.

Parameters:
WBUF_DEPTH, 4, write-buffer entries; power of two, >= 2.
STRICT_ORDER, 1, 1: every read waits until the buffer is empty and the write engine is idle. 0: a read waits only if a buffered or in-flight write has the same word address (address[31:2]).

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
uncached_read  input  1  read request, held until stall=0
uncached_write  input  1  write request; mutually exclusive with uncached_read
address  input  32  word-aligned physical address
wrdata  input  32  write data
byteenable  input  4  write byte strobes
uncached_stall  output  1  request not yet complete
uncached_rddata  output  32  read data, valid when the read completes
axi_req  output  axi_req_t  AXI master request signals
axi_resp  input  axi_resp_t  AXI slave response signals
wbuf_empty  output  1  buffer empty and write engine idle

Behaviour:
- One clock (clk); reset rst is synchronous and active-high.
- Reset state: FIFO pointers and count = 0; read FSM = R_IDLE; write FSM = W_IDLE.
- Reset values: all AXI valid/ready outputs = 0; uncached_rddata = 0; wbuf_empty = 1.
- Reset mid-transaction aborts immediately; the AXI slave is reset with the block.

Write path:
- Entry = {address, wrdata, byteenable}.
- uncached_stall for a write is combinational = (count == WBUF_DEPTH).
- A write is accepted and pushed in any cycle with uncached_write=1 and the buffer not full.
- When the buffer is full there is no same-cycle pop bypass: the write stalls at least one cycle.

Write engine:
- W_IDLE: if count > 0, load the head entry into AW/W and go to W_SEND.
- W_SEND: awvalid and wvalid are asserted together. Each drops independently after its own handshake (awvalid&awready, wvalid&wready). Both may complete in the same cycle or in either order. When both are done, go to W_RESP.
- W_RESP: bready=1. On bvalid, pop the head and go to W_IDLE. bresp is ignored.
- Back-to-back writes therefore need at least 3 cycles per entry.
- AW/W fixed fields: awlen=0, awsize=3'b010, awburst=2'b01, awlock/awcache/awprot=0, wstrb=entry byteenable, wlast=1.

Read path (read FSM):
- R_IDLE: on uncached_read, latch the address and go to R_WAIT.
- R_WAIT: blocking condition is STRICT_ORDER ? !wbuf_empty : (a word-address match in any valid FIFO entry or in the in-flight entry). When not blocked, go to R_AR.
- R_AR: arvalid=1 with araddr = latched address, arlen=0, arsize=3'b010, arburst=2'b01, other AR fields 0. On arready, go to R_R.
- R_R: rready=1. On rvalid, register rdata into uncached_rddata and go to R_DONE. rresp is ignored.
- R_DONE: uncached_stall=0 for exactly one cycle, then return to R_IDLE.
- uncached_stall for a read = 1 in every read state except R_DONE.
- Minimum read latency: 4 cycles from request to stall low with zero-wait slave (R_IDLE -> R_WAIT -> R_AR -> R_R -> R_DONE).

Concurrency and idle:
- Write retirement continues during a read. In STRICT_ORDER=0, AR may be issued while AW/W/B of a non-matching write is outstanding.
- With no request asserted, uncached_stall=0.

Test Plan:
- Idle, zero-wait slave. Write 0xDEADBEEF to 0x1FD0_F000 with be=4'b0011 -> stall=0 in the request cycle. Exactly one AW/W with awaddr=0x1FD0_F000, wstrb=4'b0011, wlast=1. wbuf_empty returns to 1 after B.
- awready and bvalid held low; 5 consecutive writes with WBUF_DEPTH=4 -> first 4 accepted with stall=0, 5th stalls. Release the slave -> 5th accepted one cycle after the first pop. AXI write order matches push order.
- STRICT_ORDER=1: 3 buffered writes, then a read of an unrelated address -> arvalid stays 0 until the third B handshake. Read data 0x12345678 is returned with stall low for exactly one cycle.
- STRICT_ORDER=0: buffered write to 0x100 with a stalled slave; read of 0x200 -> AR issued while the write is pending. Read of 0x100 instead -> AR is held until that write's B handshake.
- AW and W handshakes in separate cycles (wready 2 cycles before awready) -> wvalid drops after its handshake, awvalid stays high. A single entry is retired and popped only after bvalid.
- rst asserted while in R_R and W_SEND -> the next cycle has all valids=0, wbuf_empty=1, uncached_stall=0, and the FIFO count is 0.
